// File: rtl/branch_resolve.sv
// Branch/jump resolution stage: evaluates the condition, computes target and link,
// flags mispredicts and faults, and holds one result behind a valid/ready register.
module branch_resolve #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_kind,
   input  logic [2:0]       in_funct3,
   input  logic [31:0]      in_rs1,
   input  logic [31:0]      in_rs2,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_imm,
   input  logic             in_pred_taken,
   input  logic [31:0]      in_pred_target,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [31:0]      out_next_pc,
   output logic [31:0]      out_link,
   output logic             out_mispredict,
   output logic             out_exception,
   output logic [1:0]       out_cause,
   output logic [CNT_W-1:0] mispredict_count
);

   logic [31:0]      link_c, br_target_c, jalr_sum_c, target_c, next_pc_c;
   logic             cond_c, taken_c, illegal_c, misaligned_c, exception_c, mispredict_c;
   logic [1:0]       cause_c;
   logic             accept, consume;

   logic             valid_reg, taken_reg, mispredict_reg, exception_reg;
   logic [31:0]      next_pc_reg, link_reg;
   logic [1:0]       cause_reg;
   logic [CNT_W-1:0] count_reg;

   always_comb begin
      link_c      = in_pc + 32'd4;
      br_target_c = in_pc + in_imm;
      jalr_sum_c  = in_rs1 + in_imm;
      target_c    = br_target_c;
      cond_c      = 1'b0;
      illegal_c   = 1'b0;
      taken_c     = 1'b0;
      case (in_kind)
         2'b00: begin
            case (in_funct3[2:1])
               2'b00:   cond_c = (in_rs1 == in_rs2);
               2'b10:   cond_c = ($signed(in_rs1) < $signed(in_rs2));
               2'b11:   cond_c = (in_rs1 < in_rs2);
               default: illegal_c = 1'b1;
            endcase
            taken_c = !illegal_c && (cond_c ^ in_funct3[0]);
         end
         2'b01: taken_c = 1'b1;
         2'b10: begin
            taken_c  = 1'b1;
            target_c = {jalr_sum_c[31:1], 1'b0};
         end
         default: illegal_c = 1'b1;
      endcase

      // Illegal encodings never report taken, so they can never also be misaligned.
      misaligned_c = taken_c && (target_c[1:0] != 2'b00);
      exception_c  = illegal_c || misaligned_c;
      cause_c      = illegal_c ? 2'b01 : (misaligned_c ? 2'b10 : 2'b00);
      next_pc_c    = taken_c ? target_c : link_c;
      mispredict_c = !exception_c &&
                     ((taken_c != in_pred_taken) || (taken_c && (target_c != in_pred_target)));
   end

   assign in_ready = !valid_reg || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign consume  = valid_reg && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg      <= 1'b0;
         taken_reg      <= 1'b0;
         next_pc_reg    <= 32'd0;
         link_reg       <= 32'd0;
         mispredict_reg <= 1'b0;
         exception_reg  <= 1'b0;
         cause_reg      <= 2'b00;
         count_reg      <= '0;
      end else begin
         if (flush) begin
            valid_reg <= 1'b0;
         end else if (accept) begin
            valid_reg      <= 1'b1;
            taken_reg      <= taken_c;
            next_pc_reg    <= next_pc_c;
            link_reg       <= link_c;
            mispredict_reg <= mispredict_c;
            exception_reg  <= exception_c;
            cause_reg      <= cause_c;
         end else if (consume) begin
            valid_reg <= 1'b0;
         end
         // Count only results actually handed to the consumer; saturate at all-ones.
         if (consume && mispredict_reg && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign out_valid        = valid_reg;
   assign out_taken        = taken_reg;
   assign out_next_pc      = next_pc_reg;
   assign out_link         = link_reg;
   assign out_mispredict   = mispredict_reg;
   assign out_exception    = exception_reg;
   assign out_cause        = cause_reg;
   assign mispredict_count = count_reg;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: hand-computed vectors covering conditions,
// faults, backpressure, flush, counter saturation and mid-stream reset.
module tb_branch_resolve;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_kind;
   logic [2:0]       in_funct3;
   logic [31:0]      in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
   logic             in_pred_taken;
   logic             flush;
   logic             out_valid, out_ready, out_taken, out_mispredict, out_exception;
   logic [31:0]      out_next_pc, out_link;
   logic [1:0]       out_cause;
   logic [CNT_W-1:0] mispredict_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   branch_resolve #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_funct3(in_funct3),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
      .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_next_pc(out_next_pc), .out_link(out_link),
      .out_mispredict(out_mispredict), .out_exception(out_exception),
      .out_cause(out_cause), .mispredict_count(mispredict_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] kind, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic pt, input logic [31:0] ptgt);
      in_kind = kind; in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2;
      in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
   endtask

   task automatic send(input logic [1:0] kind, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt);
      set_req(kind, f3, rs1, rs2, pc, imm, pt, ptgt);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic chk_res(input string tag, input logic tk, input logic [31:0] npc,
                          input logic mp, input logic [1:0] cause);
      chk({tag, ".valid"},   {31'd0, out_valid},      32'd1);
      chk({tag, ".taken"},   {31'd0, out_taken},      {31'd0, tk});
      chk({tag, ".next_pc"}, out_next_pc,             npc);
      chk({tag, ".mispred"}, {31'd0, out_mispredict}, {31'd0, mp});
      chk({tag, ".exc"},     {31'd0, out_exception},  {31'd0, (cause != 2'b00)});
      chk({tag, ".cause"},   {30'd0, out_cause},      {30'd0, cause});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      set_req(2'b00, 3'b000, 0, 0, 0, 0, 1'b0, 0);
      step(); step();
      reset = 1'b0;
      step();
      chk("rst.valid",   {31'd0, out_valid}, 32'd0);
      chk("rst.taken",   {31'd0, out_taken}, 32'd0);
      chk("rst.next_pc", out_next_pc, 32'd0);
      chk("rst.link",    out_link, 32'd0);
      chk("rst.exc",     {31'd0, out_exception}, 32'd0);
      chk("rst.cause",   {30'd0, out_cause}, 32'd0);
      chk("rst.count",   {30'd0, mispredict_count}, 32'd0);
      chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

      // BEQ taken, predicted not-taken
      send(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
      chk_res("beq", 1'b1, 32'h120, 1'b1, 2'b00);
      chk("beq.link", out_link, 32'h104);
      chk("beq.count_before", {30'd0, mispredict_count}, 32'd0);
      out_ready = 1'b1;
      step();
      chk("beq.count_after", {30'd0, mispredict_count}, 32'd1);
      chk("beq.drained", {31'd0, out_valid}, 32'd0);

      // Back-to-back stream with out_ready held high
      send(2'b00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 1'b1, 32'h208);
      chk_res("blt", 1'b1, 32'h208, 1'b0, 2'b00);
      send(2'b00, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 1'b0, 32'h0);
      chk_res("bltu", 1'b0, 32'h204, 1'b0, 2'b00);
      send(2'b00, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8, 1'b0, 32'h0);
      chk_res("bgeu", 1'b1, 32'h208, 1'b1, 2'b00);
      send(2'b10, 3'b000, 32'h203, 32'd0, 32'h40, 32'h0, 1'b0, 32'h0);
      chk_res("jalr_mis", 1'b1, 32'h202, 1'b0, 2'b10);
      chk("jalr_mis.link", out_link, 32'h44);
      chk("bgeu.count", {30'd0, mispredict_count}, 32'd2);
      send(2'b00, 3'b010, 32'd1, 32'd1, 32'h80, 32'h4, 1'b1, 32'h84);
      chk_res("ill_f3", 1'b0, 32'h84, 1'b0, 2'b01);
      send(2'b11, 3'b000, 32'd0, 32'd0, 32'h90, 32'h10, 1'b1, 32'hA0);
      chk_res("ill_kind", 1'b0, 32'h94, 1'b0, 2'b01);
      send(2'b01, 3'b000, 32'd0, 32'd0, 32'h300, 32'h100, 1'b1, 32'h400);
      chk_res("jal_ok", 1'b1, 32'h400, 1'b0, 2'b00);
      send(2'b00, 3'b001, 32'd7, 32'd7, 32'h600, 32'h40, 1'b0, 32'hDEAD);
      chk_res("bne_nt", 1'b0, 32'h604, 1'b0, 2'b00);
      send(2'b01, 3'b000, 32'd0, 32'd0, 32'h300, 32'h100, 1'b1, 32'h404);
      chk_res("jal_badtgt", 1'b1, 32'h400, 1'b1, 2'b00);
      chk("stream.count", {30'd0, mispredict_count}, 32'd2);

      // Stall: held result must not move, new request ignored
      out_ready = 1'b0;
      set_req(2'b00, 3'b000, 32'd1, 32'd2, 32'h500, 32'h10, 1'b0, 32'h0);
      in_valid = 1'b1;
      #1;
      chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall.next_pc", out_next_pc, 32'h400);
         chk("stall.mispred", {31'd0, out_mispredict}, 32'd1);
         chk("stall.count", {30'd0, mispredict_count}, 32'd2);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall.in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk_res("unstall", 1'b0, 32'h504, 1'b0, 2'b00);
      chk("unstall.count", {30'd0, mispredict_count}, 32'd3);

      // Flush drops held mispredict and the concurrent request
      reset = 1'b1;
      step();
      reset = 1'b0;
      out_ready = 1'b0;
      send(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
      chk_res("pre_flush", 1'b1, 32'h120, 1'b1, 2'b00);
      set_req(2'b01, 3'b000, 0, 0, 32'h700, 32'h8, 1'b0, 32'h0);
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush.valid", {31'd0, out_valid}, 32'd0);
      chk("flush.count", {30'd0, mispredict_count}, 32'd0);
      step();
      chk("flush.still_empty", {31'd0, out_valid}, 32'd0);

      // Saturation with CNT_W=2
      send(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
      chk("sat.c0", {30'd0, mispredict_count}, 32'd0);
      send(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
      chk("sat.c1", {30'd0, mispredict_count}, 32'd1);
      send(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
      chk("sat.c2", {30'd0, mispredict_count}, 32'd2);
      send(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
      chk("sat.c3", {30'd0, mispredict_count}, 32'd3);
      send(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
      chk("sat.c4", {30'd0, mispredict_count}, 32'd3);
      step();
      chk("sat.c5", {30'd0, mispredict_count}, 32'd3);

      // Reset while a result is held
      out_ready = 1'b0;
      send(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
      chk("midrst.held", {31'd0, out_valid}, 32'd1);
      reset = 1'b1; flush = 1'b0;
      step();
      reset = 1'b0;
      chk("midrst.valid", {31'd0, out_valid}, 32'd0);
      chk("midrst.count", {30'd0, mispredict_count}, 32'd0);
      chk("midrst.next_pc", out_next_pc, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
